// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction size, default reset PC
// and the {pc, instruction} entry carried through the fetch queue.
package instruction_fetch_pkg;

   localparam int FETCH_WIDTH = 32;
   localparam int INST_BYTES  = 4;

   localparam logic [FETCH_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [FETCH_WIDTH-1:0] pc;
      logic [FETCH_WIDTH-1:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instruction} entries with flush.
// Storage is cleared on reset so the head reads as zero until written.
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             push_entry,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head_entry
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;

   // Flush resets pointers but leaves stale storage; count gates visibility.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_entry;
            tail      <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_entry = mem[head];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register driving instruction memory, a fetch queue toward
// decode, and redirect handling that flushes the queue and restarts fetch.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH  = FETCH_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int                    QUEUE_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_instruction,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instruction
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] pc;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   fetch_entry_t          push_entry;
   fetch_entry_t          head_entry;

   // A full queue may still accept a push when the head leaves this cycle.
   assign pop  = out_valid & out_ready;
   assign push = fetch_en & ~redirect_valid & ((count < CW'(QUEUE_DEPTH)) | pop);

   assign push_entry.pc          = pc;
   assign push_entry.instruction = imem_instruction;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (push) begin
         pc <= pc + DATA_WIDTH'(INST_BYTES);
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .count      (count),
      .head_entry (head_entry)
   );

   assign imem_addr       = pc;
   assign out_valid       = (count != '0);
   assign out_pc          = out_valid ? head_entry.pc          : '0;
   assign out_instruction = out_valid ? head_entry.instruction : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic compared against a queue-based reference model of the fetch stage.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instruction;

   int total = 0;
   int bad   = 0;

   // Reference model: architectural PC and an ordered list of pending entries.
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_qpc[$];
   logic [31:0] m_qins[$];

   instruction_fetch dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_en         (fetch_en),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_addr        (imem_addr),
      .imem_instruction (imem_instruction),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_pc           (out_pc),
      .out_instruction  (out_instruction)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   assign imem_instruction = mem_word(imem_addr);

   // Advance the model with the inputs in force, then step the DUT one edge.
   task automatic tick();
      bit popped;
      bit can_push;
      if (rst) begin
         m_qpc.delete();
         m_qins.delete();
         m_pc = 32'h0;
      end else begin
         popped = (m_qpc.size() != 0) && out_ready;
         if (redirect_valid) begin
            m_qpc.delete();
            m_qins.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            can_push = fetch_en && ((m_qpc.size() < 2) || popped);
            if (popped) begin
               void'(m_qpc.pop_front());
               void'(m_qins.pop_front());
            end
            if (can_push) begin
               m_qpc.push_back(m_pc);
               m_qins.push_back(mem_word(m_pc));
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
      total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", out_pc); end
      total++; if (out_instruction !== 32'h0) begin bad++; $display("[TB] FAIL reset_ins got=%h want=0", out_instruction); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", imem_addr); end
   endtask

   task automatic test_stream();
      rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
            bad++; $display("[TB] FAIL stream_pc%0d got=%b/%h want=1/%h", k, out_valid, out_pc, 32'(4 * k));
         end
         total++; if (out_instruction !== 32'h1000_0000 + 32'(k)) begin
            bad++; $display("[TB] FAIL stream_ins%0d got=%h want=%h", k, out_instruction, 32'h1000_0000 + 32'(k));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] seen[$];
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0; fetch_en = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("[TB] FAIL bp_head got=%b/%h want=1/0", out_valid, out_pc); end
      total++; if (imem_addr !== 32'h8) begin bad++; $display("[TB] FAIL bp_stall_addr got=%h want=8", imem_addr); end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (out_valid) seen.push_back(out_pc);
         tick();
      end
      total++; if (seen.size() !== 3) begin bad++; $display("[TB] FAIL bp_release_count got=%0d want=3", seen.size()); end
      for (int k = 0; k < 3 && k < seen.size(); k++) begin
         total++; if (seen[k] !== 32'(4 * k)) begin bad++; $display("[TB] FAIL bp_release%0d got=%h want=%h", k, seen[k], 32'(4 * k)); end
      end
   endtask

   task automatic test_redirect();
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0; fetch_en = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_flush got=%b want=0", out_valid); end
      total++; if (imem_addr !== 32'h100) begin bad++; $display("[TB] FAIL redir_addr got=%h want=100", imem_addr); end
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin bad++; $display("[TB] FAIL redir_target got=%b/%h want=1/100", out_valid, out_pc); end
      total++; if (out_instruction !== 32'h1000_0040) begin bad++; $display("[TB] FAIL redir_ins got=%h want=10000040", out_instruction); end
   endtask

   task automatic test_fetch_disable();
      logic [31:0] held;
      held = m_pc;
      out_ready = 1'b1; fetch_en = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL dis_drain got=%b want=0", out_valid); end
      total++; if (imem_addr !== held) begin bad++; $display("[TB] FAIL dis_hold got=%h want=%h", imem_addr, held); end
      fetch_en = 1'b1;
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== held) begin bad++; $display("[TB] FAIL dis_resume got=%b/%h want=1/%h", out_valid, out_pc, held); end
   endtask

   task automatic test_wrap();
      logic [31:0] want[3];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0;
      out_ready = 1'b1; fetch_en = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (out_valid !== 1'b1 || out_pc !== want[k]) begin
            bad++; $display("[TB] FAIL wrap%0d got=%b/%h want=1/%h", k, out_valid, out_pc, want[k]);
         end
      end
   endtask

   task automatic test_reset_override();
      out_ready = 1'b0; fetch_en = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      total++; if (out_pc !== 32'h40 || imem_addr !== 32'h48) begin bad++; $display("[TB] FAIL ovr_setup got=%h/%h want=40/48", out_pc, imem_addr); end
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
      total++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instruction !== 32'h0) begin
         bad++; $display("[TB] FAIL ovr_outputs got=%b/%h/%h want=0/0/0", out_valid, out_pc, out_instruction);
      end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("[TB] FAIL ovr_addr got=%h want=0", imem_addr); end
   endtask

   task automatic test_random();
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      bit          e_valid;
      for (int n = 0; n < 600; n++) begin
         rst            = ($urandom_range(99) < 2);
         redirect_valid = ($urandom_range(99) < 8);
         redirect_pc    = $urandom();
         fetch_en       = ($urandom_range(99) < 80);
         out_ready      = ($urandom_range(99) < 60);
         tick();
         e_valid = (m_qpc.size() != 0);
         e_pc    = e_valid ? m_qpc[0]  : 32'h0;
         e_ins   = e_valid ? m_qins[0] : 32'h0;
         total++; if (out_valid !== e_valid || out_pc !== e_pc || out_instruction !== e_ins || imem_addr !== m_pc) begin
            bad++;
            $display("[TB] FAIL rand%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", n,
                     out_valid, out_pc, out_instruction, imem_addr, e_valid, e_pc, e_ins, m_pc);
         end
      end
      rst = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_fetch_disable();
      test_wrap();
      test_reset_override();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
